// File: rtl/prco_mem_dma.sv
// ---------------------------------------------------------------------------
// prco_mem_dma
//
// Block-transfer initiator for the PRCO local memory port (prco_lmem).
// It takes one fill or copy command at a time and drives the memory's
// write-enable, address and write-data lines itself. A fill writes one
// constant word to len consecutive addresses. A copy alternates a read
// cycle and a write cycle per word, in strictly ascending order. Because
// of that ordering, an overlapping copy with dst = src + 1 propagates the
// first source word forward. All address arithmetic wraps modulo 2^ADDR_W.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_cmd_valid/q_cmd_ready command handshake (ready only while idle)
//   i_cmd_op                0 = fill, 1 = copy
//   i_cmd_src/dst/len       source base, destination base, word count
//   i_cmd_data              fill value
//   i_abort                 terminate the running transfer
//   q_busy                  not idle
//   q_done, q_aborted       one-cycle completion pulses
//   q_count                 words written in the current/last transfer
//   q_mem_we/addr/dina      memory write-enable, address, write data
//   i_mem_douta             memory read data, one cycle after the address
// ---------------------------------------------------------------------------
module prco_mem_dma #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              q_cmd_ready,
    input  logic              i_cmd_op,
    input  logic [ADDR_W-1:0] i_cmd_src,
    input  logic [ADDR_W-1:0] i_cmd_dst,
    input  logic [ADDR_W-1:0] i_cmd_len,
    input  logic [DATA_W-1:0] i_cmd_data,
    input  logic              i_abort,
    output logic              q_busy,
    output logic              q_done,
    output logic              q_aborted,
    output logic [ADDR_W-1:0] q_count,
    output logic              q_mem_we,
    output logic [ADDR_W-1:0] q_mem_addr,
    output logic [DATA_W-1:0] q_mem_dina,
    input  logic [DATA_W-1:0] i_mem_douta
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t            state_r, state_n;
    logic [ADDR_W-1:0] src_r, src_n;
    logic [ADDR_W-1:0] dst_r, dst_n;
    logic [ADDR_W-1:0] len_r, len_n;
    logic [DATA_W-1:0] fill_r, fill_n;
    logic [ADDR_W-1:0] count_r, count_n;
    logic [ADDR_W-1:0] addr_r, addr_n;
    logic [DATA_W-1:0] dina_r, dina_n;
    logic              we_r, we_n;
    logic              done_r, done_n;
    logic              aborted_r, aborted_n;
    logic              busy_r;
    logic              ready_r;
    logic [ADDR_W-1:0] count_inc;

    // The word index of the transfer is the number of words already
    // written, so q_count doubles as the offset from src/dst.
    assign count_inc = count_r + ADDR_W'(1);

    // Next-state logic. The memory-side outputs are computed here for the
    // *following* cycle and then registered, so each state's drive values
    // are prepared on the transition into it.
    always_comb begin
        state_n   = state_r;
        src_n     = src_r;
        dst_n     = dst_r;
        len_n     = len_r;
        fill_n    = fill_r;
        count_n   = count_r;
        addr_n    = addr_r;
        dina_n    = dina_r;
        we_n      = 1'b0;
        done_n    = 1'b0;
        aborted_n = 1'b0;

        unique case (state_r)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    src_n   = i_cmd_src;
                    dst_n   = i_cmd_dst;
                    len_n   = i_cmd_len;
                    fill_n  = i_cmd_data;
                    count_n = '0;
                    if (i_cmd_len == '0) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                    end else if (!i_cmd_op) begin
                        state_n = S_FILL;
                        we_n    = 1'b1;
                        addr_n  = i_cmd_dst;
                        dina_n  = i_cmd_data;
                    end else begin
                        state_n = S_RD;
                        addr_n  = i_cmd_src;
                    end
                end
            end

            S_FILL: begin
                count_n = count_inc;
                if (i_abort) begin
                    state_n   = S_IDLE;
                    aborted_n = 1'b1;
                end else if (count_inc == len_r) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                end else begin
                    we_n   = 1'b1;
                    addr_n = dst_r + count_inc;
                end
            end

            S_RD: begin
                if (i_abort) begin
                    state_n   = S_IDLE;
                    aborted_n = 1'b1;
                end else begin
                    state_n = S_WR;
                    we_n    = 1'b1;
                    addr_n  = dst_r + count_r;
                end
            end

            S_WR: begin
                count_n = count_inc;
                // Keep the written word so dina holds it after the write.
                dina_n  = i_mem_douta;
                if (i_abort) begin
                    state_n   = S_IDLE;
                    aborted_n = 1'b1;
                end else if (count_inc != len_r) begin
                    state_n = S_RD;
                    addr_n  = src_r + count_inc;
                end else begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                end
            end

            S_DONE: begin
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops every transfer immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= S_IDLE;
            src_r     <= '0;
            dst_r     <= '0;
            len_r     <= '0;
            fill_r    <= '0;
            count_r   <= '0;
            addr_r    <= '0;
            dina_r    <= '0;
            we_r      <= 1'b0;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
            busy_r    <= 1'b0;
            ready_r   <= 1'b1;
        end else begin
            state_r   <= state_n;
            src_r     <= src_n;
            dst_r     <= dst_n;
            len_r     <= len_n;
            fill_r    <= fill_n;
            count_r   <= count_n;
            addr_r    <= addr_n;
            dina_r    <= dina_n;
            we_r      <= we_n;
            done_r    <= done_n;
            aborted_r <= aborted_n;
            busy_r    <= (state_n != S_IDLE);
            ready_r   <= (state_n == S_IDLE);
        end
    end

    assign q_cmd_ready = ready_r;
    assign q_busy      = busy_r;
    assign q_done      = done_r;
    assign q_aborted   = aborted_r;
    assign q_count     = count_r;
    assign q_mem_we    = we_r;
    assign q_mem_addr  = addr_r;

    // The read data only arrives during the write cycle itself, so a copy
    // write forwards i_mem_douta straight through. This is selected by the
    // registered state only; every other cycle uses the registered value.
    assign q_mem_dina  = (state_r == S_WR) ? i_mem_douta : dina_r;

endmodule

// File: tb/tb_prco_mem_dma.sv
// ---------------------------------------------------------------------------
// tb_prco_mem_dma
//
// Directed bench for prco_mem_dma. It contains a one-cycle-latency memory
// that stands in for prco_lmem.
//
// For every command, a transfer-level model does two things:
//   - It builds the list of per-cycle outputs the block must show.
//   - It updates a reference memory image.
// One compare process checks the DUT against that list on every falling
// edge. Literal expected values after each transfer pin the model itself.
// ---------------------------------------------------------------------------
module tb_prco_mem_dma;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_cmd_valid;
    logic              q_cmd_ready;
    logic              i_cmd_op;
    logic [ADDR_W-1:0] i_cmd_src;
    logic [ADDR_W-1:0] i_cmd_dst;
    logic [ADDR_W-1:0] i_cmd_len;
    logic [DATA_W-1:0] i_cmd_data;
    logic              i_abort;
    logic              q_busy;
    logic              q_done;
    logic              q_aborted;
    logic [ADDR_W-1:0] q_count;
    logic              q_mem_we;
    logic [ADDR_W-1:0] q_mem_addr;
    logic [DATA_W-1:0] q_mem_dina;
    logic [DATA_W-1:0] i_mem_douta;

    // Bench-side preload port into the memory.
    logic              pre_we;
    logic [ADDR_W-1:0] pre_addr;
    logic [DATA_W-1:0] pre_data;

    logic [DATA_W-1:0] mem       [0:65535];
    logic [DATA_W-1:0] model_mem [0:65535];

    typedef struct packed {
        logic        we;
        logic        chk_addr;
        logic [15:0] addr;
        logic [15:0] dina;
        logic [15:0] count;
        logic        done;
        logic        aborted;
        logic        busy;
        logic        ready;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_exp;

    int n_checks = 0;
    int n_fail   = 0;

    prco_mem_dma #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_cmd_valid (i_cmd_valid),
        .q_cmd_ready (q_cmd_ready),
        .i_cmd_op    (i_cmd_op),
        .i_cmd_src   (i_cmd_src),
        .i_cmd_dst   (i_cmd_dst),
        .i_cmd_len   (i_cmd_len),
        .i_cmd_data  (i_cmd_data),
        .i_abort     (i_abort),
        .q_busy      (q_busy),
        .q_done      (q_done),
        .q_aborted   (q_aborted),
        .q_count     (q_count),
        .q_mem_we    (q_mem_we),
        .q_mem_addr  (q_mem_addr),
        .q_mem_dina  (q_mem_dina),
        .i_mem_douta (i_mem_douta)
    );

    // 100 MHz-style free-running clock.
    always #5 i_clk = ~i_clk;

    // Synchronous-write, registered-read memory, like prco_lmem.
    always @(posedge i_clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (q_mem_we)
            mem[q_mem_addr] <= q_mem_dina;
        i_mem_douta <= mem[q_mem_addr];
    end

    // One comparison: bumps the counters and reports a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pushExp(input logic we, input logic chk, input logic [15:0] addr,
                           input logic [15:0] dina, input logic [15:0] count,
                           input logic done, input logic ab, input logic busy,
                           input logic ready);
        exp_t e;
        e.we = we; e.chk_addr = chk; e.addr = addr; e.dina = dina; e.count = count;
        e.done = done; e.aborted = ab; e.busy = busy; e.ready = ready;
        exp_q.push_back(e);
    endtask

    // Transfer-level model: expected outputs for cycles T+1, T+2, ...
    // abort_at = n means abort is sampled at the end of cycle T+n.
    task automatic buildTrace(input logic op, input logic [15:0] src, input logic [15:0] dst,
                              input logic [15:0] len, input logic [15:0] data, input int abort_at);
        int          m;
        logic        ab;
        logic [15:0] v;
        ab = 1'b0;
        if (!op || len == 16'd0) begin
            m = int'(len);
            if (abort_at > 0 && abort_at <= m) begin
                m  = abort_at;
                ab = 1'b1;
            end
            for (int c = 0; c < m; c++) begin
                pushExp(1'b1, 1'b1, 16'(dst + c), data, 16'(c), 1'b0, 1'b0, 1'b1, 1'b0);
                model_mem[16'(dst + c)] = data;
            end
            if (ab)
                pushExp(1'b0, 1'b0, 16'd0, 16'd0, 16'(m), 1'b0, 1'b1, 1'b0, 1'b1);
        end else begin
            for (int k = 0; k < int'(len); k++) begin
                pushExp(1'b0, 1'b1, 16'(src + k), 16'd0, 16'(k), 1'b0, 1'b0, 1'b1, 1'b0);
                v = model_mem[16'(src + k)];
                model_mem[16'(dst + k)] = v;
                pushExp(1'b1, 1'b1, 16'(dst + k), v, 16'(k), 1'b0, 1'b0, 1'b1, 1'b0);
            end
        end
        if (!ab) begin
            pushExp(1'b0, 1'b0, 16'd0, 16'd0, len, 1'b1, 1'b0, 1'b1, 1'b0);
            pushExp(1'b0, 1'b0, 16'd0, 16'd0, len, 1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    // Compare process: DUT outputs against the model on every falling edge.
    always @(negedge i_clk) begin
        if (i_rst_n && exp_q.size() > 0) begin
            cur_exp = exp_q.pop_front();
            checkOutput("mem_we", 32'(q_mem_we), 32'(cur_exp.we));
            if (cur_exp.chk_addr)
                checkOutput("mem_addr", 32'(q_mem_addr), 32'(cur_exp.addr));
            if (cur_exp.we)
                checkOutput("mem_dina", 32'(q_mem_dina), 32'(cur_exp.dina));
            checkOutput("count", 32'(q_count), 32'(cur_exp.count));
            checkOutput("done", 32'(q_done), 32'(cur_exp.done));
            checkOutput("aborted", 32'(q_aborted), 32'(cur_exp.aborted));
            checkOutput("busy", 32'(q_busy), 32'(cur_exp.busy));
            checkOutput("cmd_ready", 32'(q_cmd_ready), 32'(cur_exp.ready));
        end
    end

    task automatic preload(input logic [15:0] addr, input logic [15:0] data);
        @(negedge i_clk);
        pre_we   = 1'b1;
        pre_addr = addr;
        pre_data = data;
        @(posedge i_clk);
        #1;
        pre_we = 1'b0;
        model_mem[addr] = data;
    endtask

    // Issue one command and, optionally, an abort sampled at edge T+abort_at.
    task automatic applyStimulus(input logic op, input logic [15:0] src, input logic [15:0] dst,
                                 input logic [15:0] len, input logic [15:0] data, input int abort_at);
        @(negedge i_clk);
        i_cmd_op    = op;
        i_cmd_src   = src;
        i_cmd_dst   = dst;
        i_cmd_len   = len;
        i_cmd_data  = data;
        i_cmd_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_cmd_valid = 1'b0;
        buildTrace(op, src, dst, len, data, abort_at);
        if (abort_at > 0) begin
            repeat (abort_at - 1) @(posedge i_clk);
            #1;
            i_abort = 1'b1;
            @(posedge i_clk);
            #1;
            i_abort = 1'b0;
        end
    endtask

    // Bounded wait for the compare process to consume the expected trace.
    task automatic waitIdle(input int max_cycles);
        int i;
        i = 0;
        while (exp_q.size() > 0 && i < max_cycles) begin
            @(posedge i_clk);
            i++;
        end
        checkOutput("trace_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        #1;
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_op    = 1'b0;
        i_cmd_src   = '0;
        i_cmd_dst   = '0;
        i_cmd_len   = '0;
        i_cmd_data  = '0;
        i_abort     = 1'b0;
        pre_we      = 1'b0;
        pre_addr    = '0;
        pre_data    = '0;

        // Reset values.
        #12;
        checkOutput("rst_ready", 32'(q_cmd_ready), 32'd1);
        checkOutput("rst_busy", 32'(q_busy), 32'd0);
        checkOutput("rst_done", 32'(q_done), 32'd0);
        checkOutput("rst_aborted", 32'(q_aborted), 32'd0);
        checkOutput("rst_count", 32'(q_count), 32'd0);
        checkOutput("rst_we", 32'(q_mem_we), 32'd0);
        checkOutput("rst_addr", 32'(q_mem_addr), 32'd0);
        checkOutput("rst_dina", 32'(q_mem_dina), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        preload(16'h0000, 16'h00ab);
        preload(16'h0001, 16'h00cd);
        preload(16'h0007, 16'hdead);
        preload(16'h0010, 16'h1234);
        preload(16'h0011, 16'h1111);
        preload(16'h0012, 16'h2222);
        preload(16'h0013, 16'h3333);
        preload(16'h0100, 16'h7777);
        for (int i = 0; i < 4; i++)
            preload(16'(16'h0020 + i), 16'(16'h00a0 + i));
        preload(16'h0031, 16'hbeef);

        $display("[TB] fill dst=0x0004 len=3");
        applyStimulus(1'b0, 16'h0000, 16'h0004, 16'd3, 16'h00ab, 0);
        waitIdle(20);
        checkOutput("fill_count", 32'(q_count), 32'd3);
        checkOutput("fill_mem4", 32'(mem[16'h0004]), 32'h00ab);
        checkOutput("fill_mem5", 32'(mem[16'h0005]), 32'h00ab);
        checkOutput("fill_mem6", 32'(mem[16'h0006]), 32'h00ab);

        $display("[TB] copy src=0 dst=8 len=2 with a command offered while busy");
        applyStimulus(1'b1, 16'h0000, 16'h0008, 16'd2, 16'h0000, 0);
        @(negedge i_clk);
        i_cmd_op    = 1'b0;
        i_cmd_dst   = 16'h0100;
        i_cmd_len   = 16'd1;
        i_cmd_data  = 16'h9999;
        i_cmd_valid = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_cmd_valid = 1'b0;
        waitIdle(20);
        checkOutput("copy_mem8", 32'(mem[16'h0008]), 32'h00ab);
        checkOutput("copy_mem9", 32'(mem[16'h0009]), 32'h00cd);
        checkOutput("copy_ignored_cmd", 32'(mem[16'h0100]), 32'h7777);
        checkOutput("copy_count", 32'(q_count), 32'd2);

        $display("[TB] zero-length fill");
        applyStimulus(1'b0, 16'h0000, 16'h0050, 16'd0, 16'h1111, 0);
        waitIdle(10);
        checkOutput("zero_count", 32'(q_count), 32'd0);

        $display("[TB] wrapping fill dst=0xfffe len=3");
        applyStimulus(1'b0, 16'h0000, 16'hfffe, 16'd3, 16'h0c0c, 0);
        waitIdle(20);
        checkOutput("wrap_memfffe", 32'(mem[16'hfffe]), 32'h0c0c);
        checkOutput("wrap_memffff", 32'(mem[16'hffff]), 32'h0c0c);
        checkOutput("wrap_mem0", 32'(mem[16'h0000]), 32'h0c0c);

        $display("[TB] overlapping copy src=0x10 dst=0x11 len=3");
        applyStimulus(1'b1, 16'h0010, 16'h0011, 16'd3, 16'h0000, 0);
        waitIdle(20);
        checkOutput("ovl_mem11", 32'(mem[16'h0011]), 32'h1234);
        checkOutput("ovl_mem12", 32'(mem[16'h0012]), 32'h1234);
        checkOutput("ovl_mem13", 32'(mem[16'h0013]), 32'h1234);

        $display("[TB] fill len=10 aborted at T+3");
        applyStimulus(1'b0, 16'h0000, 16'h0004, 16'd10, 16'h5555, 3);
        waitIdle(20);
        checkOutput("abort_count", 32'(q_count), 32'd3);
        checkOutput("abort_mem6", 32'(mem[16'h0006]), 32'h5555);
        checkOutput("abort_mem7", 32'(mem[16'h0007]), 32'hdead);

        $display("[TB] async reset during a copy write cycle");
        applyStimulus(1'b1, 16'h0020, 16'h0030, 16'd4, 16'h0000, 0);
        repeat (3) @(posedge i_clk);
        #2;
        exp_q.delete();
        i_rst_n = 1'b0;
        #1;
        checkOutput("arst_we", 32'(q_mem_we), 32'd0);
        checkOutput("arst_ready", 32'(q_cmd_ready), 32'd1);
        checkOutput("arst_busy", 32'(q_busy), 32'd0);
        @(negedge i_clk);
        checkOutput("arst_done", 32'(q_done), 32'd0);
        checkOutput("arst_aborted", 32'(q_aborted), 32'd0);
        i_rst_n = 1'b1;
        checkOutput("arst_mem30", 32'(mem[16'h0030]), 32'h00a0);
        checkOutput("arst_mem31", 32'(mem[16'h0031]), 32'hbeef);
        for (int i = 0; i < 4; i++)
            model_mem[16'(16'h0030 + i)] = mem[16'(16'h0030 + i)];

        applyStimulus(1'b0, 16'h0000, 16'h0040, 16'd2, 16'h5a5a, 0);
        waitIdle(20);
        checkOutput("post_rst_mem40", 32'(mem[16'h0040]), 32'h5a5a);
        checkOutput("post_rst_mem41", 32'(mem[16'h0041]), 32'h5a5a);
        checkOutput("post_rst_count", 32'(q_count), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
